jzjpcc_alu_decode_reg: RTL
==========================

Name: jzjpcc_alu_decode_reg

Overview:
Producer side of the execute-stage ALU control interface. It decodes a decode-stage RV32I instruction into the ALU operation code, the ALU modifier and the two operand selections, then registers everything into the execute stage. The registers support stall, flush and a bubble valid bit. It sits on the decode/execute pipeline boundary and drives the ALU's aluOperation/aluMod and operand inputs one cycle later.

Parameters:
RESET_PC, 32'h00000000, value loaded into pc_execute on reset

Ports:
clock  input  1  pipeline clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
stall  input  1  hold all execute-side registers
flush  input  1  replace the next execute contents with a bubble
valid_decode  input  1  decode slot holds a real instruction
instruction_decode  input  32  raw instruction
pc_decode  input  32  instruction address
rs1Data_decode  input  32  register file read port 1 (forwarding already applied)
rs2Data_decode  input  32  register file read port 2 (forwarding already applied)
aluOperation_execute  output  3  funct3-encoded ALU op
aluMod_execute  output  1  1 = sub / sra
aluOperandA_execute  output  32  rs1, pc or zero
aluOperandB_execute  output  32  rs2, immediate or 4
rd_execute  output  5  destination register
regWrite_execute  output  1  ALU result is to be written to rd
pc_execute  output  32  registered pc
valid_execute  output  1  execute slot holds a real instruction
illegal_execute  output  1  decoded ALU-class encoding is illegal

Behaviour:
- Reset (reset_n low, asynchronous, any time including mid-stall):
  - all outputs go to 0, except pc_execute = RESET_PC.
  - Takes effect immediately, not at the next edge.
- Register update priority at each rising edge:
  1. flush → bubble: valid, regWrite and illegal = 0; aluOperation 000, aluMod 0, operands 0, rd 0; pc_execute unchanged.
  2. else stall → every output holds its value.
  3. else → load the decode results for the current inputs.
- Flush together with stall: flush wins.
- Latency: exactly 1 cycle from the decode inputs to the execute outputs; no combinational path from input to output.
- Decode is on opcode = instruction[6:0], f3 = [14:12], f7 = [31:25]:
  - OP (0110011): A = rs1, B = rs2, op = f3.
    - f7 = 0000000 → mod 0.
    - f7 = 0100000 and f3 in {000, 101} → mod 1.
    - any other f7 → illegal.
  - OP-IMM (0010011): A = rs1, B = sign-extended I-imm [31:20], op = f3.
    - f3 = 001: f7 must be 0000000, else illegal.
    - f3 = 101: f7 = 0000000 → mod 0; f7 = 0100000 → mod 1; else illegal.
    - all other f3: mod 0, f7 bits are immediate.
  - LUI (0110111): A = 0, B = {[31:12], 12'b0}, op 000, mod 0.
  - AUIPC (0010111): A = pc, B = U-imm, op 000, mod 0.
  - JAL (1101111) and JALR (1100111, f3 = 000): A = pc, B = 32'd4, op 000, mod 0 (link address).
  - JALR with f3 ≠ 000 → illegal.
  - Any other opcode (load, store, branch, fence, system, unknown): regWrite 0, illegal 0, op 000, mod 0, A = rs1, B = I-imm.
- regWrite_execute = valid_decode AND ALU-class opcode AND not illegal AND rd ≠ 0.
- illegal_execute is only set when valid_decode = 1. When it is set, regWrite = 0 and the remaining fields are still loaded as decoded.
- valid_decode = 0 (without flush): load as for flush, but pc_execute = pc_decode.
- rd_execute = instruction[11:7] whenever the slot is loaded with a valid instruction.

Test Plan:
- Reset: drive reset_n low asynchronously mid-cycle while valid_execute = 1 → all outputs 0 and pc_execute = RESET_PC before the next edge; release, then addi x1,x0,5 (0x00500093) → next cycle op 000, mod 0, A = rs1Data, B = 5, rd 1, regWrite 1.
- ALU op sweep: sub x3,x1,x2 (0x402081B3) → op 000, mod 1, B = rs2; srai x5,x5,3 (0x4032D293) → op 101, mod 1, B = 0x403 (ALU uses B[4:0] = 3); slti x1,x0,-1 (0xFFF02093) → B = 0xFFFFFFFF.
- Immediate/pc forms: lui x7,0xABCDE (0xABCDE3B7) → A = 0, B = 0xABCDE000; jal with pc_decode = 0x100 → A = 0x100, B = 4, regWrite 1; addi x0,x0,0 → regWrite 0.
- Illegal encodings: add with f7 = 0000001 → illegal 1, regWrite 0, valid 1; slli with f7 = 0100000 → illegal 1; same encoding with valid_decode = 0 → illegal 0.
- Stall: present add, then hold stall = 1 for 3 cycles while changing the decode inputs → outputs frozen; release → next cycle loads the current inputs.
- Flush over stall: stall = 1 and flush = 1 together → valid 0, regWrite 0, operands 0, pc_execute unchanged; a store opcode → regWrite 0, illegal 0.

Source files
------------

// File: rtl/jzjpcc_alu_decode_reg_if.sv
// Decode-to-execute ALU control bundle: pipeline control and decode inputs
// toward the register stage, registered execute-side ALU controls back out.
interface jzjpcc_alu_decode_reg_if;
    logic        stall;
    logic        flush;
    logic        valid_decode;
    logic [31:0] instruction_decode;
    logic [31:0] pc_decode;
    logic [31:0] rs1Data_decode;
    logic [31:0] rs2Data_decode;

    logic [2:0]  aluOperation_execute;
    logic        aluMod_execute;
    logic [31:0] aluOperandA_execute;
    logic [31:0] aluOperandB_execute;
    logic [4:0]  rd_execute;
    logic        regWrite_execute;
    logic [31:0] pc_execute;
    logic        valid_execute;
    logic        illegal_execute;

    modport master (
        output stall, flush, valid_decode, instruction_decode, pc_decode,
               rs1Data_decode, rs2Data_decode,
        input  aluOperation_execute, aluMod_execute, aluOperandA_execute,
               aluOperandB_execute, rd_execute, regWrite_execute, pc_execute,
               valid_execute, illegal_execute
    );

    modport slave (
        input  stall, flush, valid_decode, instruction_decode, pc_decode,
               rs1Data_decode, rs2Data_decode,
        output aluOperation_execute, aluMod_execute, aluOperandA_execute,
               aluOperandB_execute, rd_execute, regWrite_execute, pc_execute,
               valid_execute, illegal_execute
    );
endinterface

// File: rtl/jzjpcc_alu_decode_reg.sv
// RV32I decode of ALU controls and operands, registered into the execute stage
// with stall, flush and bubble handling.
module jzjpcc_alu_decode_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                    clock,
    input logic                    reset_n,
    jzjpcc_alu_decode_reg_if.slave bus
);
    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;

    logic [2:0]      op_c;
    logic            mod_c;
    logic [XLEN-1:0] a_c;
    logic [XLEN-1:0] b_c;
    logic            alu_class_c;
    logic            bad_enc_c;
    logic            illegal_c;
    logic            reg_write_c;

    assign opcode = bus.instruction_decode[6:0];
    assign f3     = bus.instruction_decode[14:12];
    assign f7     = bus.instruction_decode[31:25];
    assign rd     = bus.instruction_decode[11:7];
    assign imm_i  = {{(XLEN-12){bus.instruction_decode[31]}}, bus.instruction_decode[31:20]};
    assign imm_u  = {bus.instruction_decode[31:12], 12'b0};

    // Non-ALU opcodes fall through with rs1 / I-imm and no write-back.
    always_comb begin
        op_c        = 3'b000;
        mod_c       = 1'b0;
        a_c         = bus.rs1Data_decode;
        b_c         = imm_i;
        alu_class_c = 1'b0;
        bad_enc_c   = 1'b0;
        case (opcode)
            OPC_OP: begin
                alu_class_c = 1'b1;
                b_c         = bus.rs2Data_decode;
                op_c        = f3;
                if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
                    mod_c = 1'b1;
                end else if (f7 != F7_ZERO) begin
                    bad_enc_c = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                alu_class_c = 1'b1;
                op_c        = f3;
                if (f3 == 3'b001) begin
                    bad_enc_c = (f7 != F7_ZERO);
                end else if (f3 == 3'b101) begin
                    if (f7 == F7_ALT) begin
                        mod_c = 1'b1;
                    end else if (f7 != F7_ZERO) begin
                        bad_enc_c = 1'b1;
                    end
                end
            end
            OPC_LUI: begin
                alu_class_c = 1'b1;
                a_c         = '0;
                b_c         = imm_u;
            end
            OPC_AUIPC: begin
                alu_class_c = 1'b1;
                a_c         = bus.pc_decode;
                b_c         = imm_u;
            end
            OPC_JAL, OPC_JALR: begin
                // Link address pc + 4 is produced by the ALU.
                alu_class_c = 1'b1;
                a_c         = bus.pc_decode;
                b_c         = XLEN'(4);
                bad_enc_c   = (opcode == OPC_JALR) && (f3 != 3'b000);
            end
            default: ;
        endcase
    end

    assign illegal_c   = bus.valid_decode & bad_enc_c;
    assign reg_write_c = bus.valid_decode & alu_class_c & ~bad_enc_c & (rd != 5'd0);

    // Flush beats stall; an invalid decode slot loads a bubble carrying its pc.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.aluOperation_execute <= 3'b000;
            bus.aluMod_execute       <= 1'b0;
            bus.aluOperandA_execute  <= '0;
            bus.aluOperandB_execute  <= '0;
            bus.rd_execute           <= 5'd0;
            bus.regWrite_execute     <= 1'b0;
            bus.pc_execute           <= RESET_PC;
            bus.valid_execute        <= 1'b0;
            bus.illegal_execute      <= 1'b0;
        end else if (bus.flush || (!bus.stall && !bus.valid_decode)) begin
            bus.aluOperation_execute <= 3'b000;
            bus.aluMod_execute       <= 1'b0;
            bus.aluOperandA_execute  <= '0;
            bus.aluOperandB_execute  <= '0;
            bus.rd_execute           <= 5'd0;
            bus.regWrite_execute     <= 1'b0;
            bus.valid_execute        <= 1'b0;
            bus.illegal_execute      <= 1'b0;
            if (!bus.flush) begin
                bus.pc_execute <= bus.pc_decode;
            end
        end else if (!bus.stall) begin
            bus.aluOperation_execute <= op_c;
            bus.aluMod_execute       <= mod_c;
            bus.aluOperandA_execute  <= a_c;
            bus.aluOperandB_execute  <= b_c;
            bus.rd_execute           <= rd;
            bus.regWrite_execute     <= reg_write_c;
            bus.pc_execute           <= bus.pc_decode;
            bus.valid_execute        <= 1'b1;
            bus.illegal_execute      <= illegal_c;
        end
    end
endmodule
